fm_mpx_gen: RTL and testbench
=============================

Name: fm_mpx_gen

Overview:
- Parametrised FM stereo multiplex (MPX) baseband generator.
- Sits between the audio/RDS sources and the FM transmitter's PCM input.
- Replaces the single mono tone/RDS mix with L+R, a 19 kHz pilot, a 38 kHz DSB-SC L-R subcarrier and a 57 kHz RDS subcarrier. All carriers are phase-locked to one accumulator.
- Computes one saturated PCM_W-bit sample per internal sample tick, using a pipeline.

Parameters:
- PCM_W, 16: width of all signed PCM inputs and of pcm_out.
- SAMPLE_DIV, 25: clocks per output sample, >=2 (1 MHz sample rate at 25 MHz).
- PHASE_W, 32: pilot phase accumulator width.
- PILOT_INC, 81604379: accumulator increment per sample, round(19000*2^PHASE_W/sample rate).
- SINE_ADDR_W, 8: sine LUT address width.
- PILOT_AMP, 3277: pilot amplitude, unsigned, Q(PCM_W-1) fraction of full scale.
- RDS_SHIFT, 2: extra arithmetic right shift on the RDS term.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- stereo_en  in  1  1 = stereo MPX, 0 = mono.
- rds_en  in  1  1 = add the 57 kHz RDS term.
- pcm_left  in  PCM_W  signed left audio.
- pcm_right  in  PCM_W  signed right audio.
- pcm_rds  in  PCM_W  signed, pre-shaped RDS baseband.
- sample_tick  out  1  one-clock pulse; inputs are captured on this cycle.
- pcm_out  out  PCM_W  signed MPX sample.
- out_valid  out  1  one-clock pulse when pcm_out is updated.

Behaviour:
- Reset (async, immediate): div counter=0, phase=0, all pipeline registers=0, pcm_out=0, out_valid=0, sample_tick=0.
- Divider:
  - Counts 0..SAMPLE_DIV-1 and wraps.
  - sample_tick=1 on the cycle where count==SAMPLE_DIV-1 (registered output). The first tick comes SAMPLE_DIV clocks after reset release.
- Capture: on a tick cycle, register pcm_left, pcm_right, pcm_rds, stereo_en, rds_en and the current phase p. The mode is constant within a sample.
- Phase update: on the same cycle, phase <= phase+PILOT_INC, modulo 2^PHASE_W. Sample n uses p=n*PILOT_INC.
- LUT addresses: top SINE_ADDR_W bits of p, 2p and 3p (each taken mod 2^PHASE_W), giving s19, s38 and s57.
- LUT contents:
  - LUT[i] = round((2^(PCM_W-1)-1)*sin(2*pi*i/2^SINE_ADDR_W)), signed PCM_W. LUT[0]=0 and LUT[N/4]=+FS.
  - Full or quarter-wave table, implementer's choice, but must be bit-exact to this formula.
- Terms (widen before adding; >>> is arithmetic; products are full width before shifting):
  - mono: (L+R)>>>2 if stereo_en, else (L+R)>>>1.
  - diff: stereo_en ? (((L-R)>>>2)*s38)>>>(PCM_W-1) : 0.
  - pilot: stereo_en ? (s19*PILOT_AMP)>>>(PCM_W-1) : 0.
  - rds: rds_en ? ((pcm_rds*s57)>>>(PCM_W-1))>>>RDS_SHIFT : 0.
- Sum: mono+diff+pilot+rds, saturated to [-2^(PCM_W-1), 2^(PCM_W-1)-1]. No wrap-around allowed.
- Pipeline (fixed):
  - T0: tick/capture.
  - T1: LUT read registered.
  - T2: products registered.
  - T3: sum and saturate into pcm_out, with out_valid=1 for exactly one clock.
  - Latency is 3 clocks from the sample_tick cycle to out_valid.
- pcm_out holds its value between out_valid pulses.
- Reset mid-pipeline: any in-flight sample is discarded; no out_valid is produced for it.
- Input changes between ticks have no effect on any output.
- Mode changes take effect from the next tick only.

Test Plan:
- Reset then release, L=R=0x4000, stereo_en=1, rds_en=0 -> first sample_tick SAMPLE_DIV clocks after release; out_valid 3 clocks later; pcm_out=0x2000 (phase 0, all sines 0).
- PILOT_INC=2^(PHASE_W-2), stereo_en=1, L=R=0, rds_en=0 -> pcm_out sequence 0, 3276, 0, -3277, repeating (s38 always 0).
- Same PILOT_INC, stereo_en=0, rds_en=1, pcm_rds=32767, RDS_SHIFT=0 -> s57 sequence 0, -FS, 0, +FS; pcm_out sequence 0, -32767, 0, 32766 ((32767*32767)>>>15).
- Saturation: stereo_en=0, L=R=32767, rds_en=1, pcm_rds=32767, at a +FS s57 sample -> pcm_out=32767.
- Saturation: same stimulus with L=R=-32768 at a -FS s57 sample -> pcm_out=-32768.
- Assert reset for 1 clock, 1 clock after a tick -> pcm_out=0, out_valid never pulses for that sample; the next tick occurs SAMPLE_DIV clocks after release and phase restarts at 0.

Source files
------------

// File: rtl/fm_mpx_gen.sv
// fm_mpx_gen: FM stereo multiplex baseband generator.
// Mixes L+R, a 19 kHz pilot, a 38 kHz DSB-SC L-R subcarrier and a 57 kHz RDS
// subcarrier. All three carriers come from one pilot phase accumulator, so they
// stay phase-locked. One saturated sample is produced per sample tick.
module fm_mpx_gen #(
    parameter int                   PCM_W       = 16,
    parameter int                   SAMPLE_DIV  = 25,
    parameter int                   PHASE_W     = 32,
    parameter logic [PHASE_W-1:0]   PILOT_INC   = 81604379,
    parameter int                   SINE_ADDR_W = 8,
    parameter int                   PILOT_AMP   = 3277,
    parameter int                   RDS_SHIFT   = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    stereo_en,
    input  logic                    rds_en,
    input  logic signed [PCM_W-1:0] pcm_left,
    input  logic signed [PCM_W-1:0] pcm_right,
    input  logic signed [PCM_W-1:0] pcm_rds,
    output logic                    sample_tick,
    output logic signed [PCM_W-1:0] pcm_out,
    output logic                    out_valid
);

    localparam int CNT_W  = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
    localparam int LUT_N  = 1 << SINE_ADDR_W;
    localparam int TERM_W = PCM_W + 2;
    localparam int SUM_W  = PCM_W + 4;
    localparam int PROD_W = 2 * PCM_W + 2;

    localparam logic signed [SUM_W-1:0] MAX_V = (SUM_W'(1) <<< (PCM_W - 1)) - SUM_W'(1);
    localparam logic signed [SUM_W-1:0] MIN_V = -(SUM_W'(1) <<< (PCM_W - 1));

    // Integer-only sine for table generation: fold the index into the first
    // quadrant, evaluate a Q60 Taylor series, then round half away from zero.
    function automatic logic signed [PCM_W-1:0] sine_entry(input int idx);
        logic signed [127:0] pi_q60;
        logic signed [127:0] theta;
        logic signed [127:0] x2;
        logic signed [127:0] term;
        logic signed [127:0] acc;
        logic signed [127:0] scaled;
        int                  j;
        bit                  neg;
        pi_q60 = 128'sh3243F6A8885A308D;
        neg    = (idx >= LUT_N / 2);
        j      = idx % (LUT_N / 2);
        if (j > LUT_N / 4) begin
            j = LUT_N / 2 - j;
        end
        theta = (pi_q60 * 128'(2 * j)) >>> SINE_ADDR_W;
        x2    = (theta * theta) >>> 60;
        term  = theta;
        acc   = theta;
        for (int k = 1; k <= 13; k++) begin
            term = -((term * x2) >>> 60) / 128'(2 * k * (2 * k + 1));
            acc  = acc + term;
        end
        scaled = (acc * ((128'sd1 <<< (PCM_W - 1)) - 128'sd1) + (128'sd1 <<< 59)) >>> 60;
        return PCM_W'(neg ? -scaled : scaled);
    endfunction

    logic signed [PCM_W-1:0] sine_lut [LUT_N];

    for (genvar g = 0; g < LUT_N; g++) begin : g_lut
        localparam logic signed [PCM_W-1:0] ENTRY = sine_entry(g);
        assign sine_lut[g] = ENTRY;
    end

    logic [CNT_W-1:0]        div_cnt;
    logic [PHASE_W-1:0]      phase;
    logic signed [PCM_W-1:0] left_r;
    logic signed [PCM_W-1:0] right_r;
    logic signed [PCM_W-1:0] rds_r;
    logic                    stereo_r;
    logic                    rds_en_r;
    logic signed [PCM_W-1:0] s19_r;
    logic signed [PCM_W-1:0] s38_r;
    logic signed [PCM_W-1:0] s57_r;
    logic                    valid_1;
    logic signed [TERM_W-1:0] mono_t;
    logic signed [TERM_W-1:0] diff_t;
    logic signed [TERM_W-1:0] pilot_t;
    logic signed [TERM_W-1:0] rds_t;
    logic                    valid_2;
    logic signed [PCM_W:0]   sum_lr;
    logic signed [PCM_W:0]   dif_lr;
    logic signed [SUM_W-1:0] sum_c;
    logic signed [PCM_W-1:0] sum_sat;

    // Free-running sample divider; the tick is registered off the terminal count
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt     <= '0;
            sample_tick <= 1'b0;
        end else begin
            sample_tick <= (div_cnt == CNT_W'(SAMPLE_DIV - 1));
            if (div_cnt == CNT_W'(SAMPLE_DIV - 1)) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + CNT_W'(1);
            end
        end
    end

    // Tick cycle: capture audio, mode and the p/2p/3p sine lookups, then advance the phase
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase    <= '0;
            left_r   <= '0;
            right_r  <= '0;
            rds_r    <= '0;
            stereo_r <= 1'b0;
            rds_en_r <= 1'b0;
            s19_r    <= '0;
            s38_r    <= '0;
            s57_r    <= '0;
            valid_1  <= 1'b0;
        end else begin
            valid_1 <= sample_tick;
            if (sample_tick) begin
                phase    <= phase + PILOT_INC;
                left_r   <= pcm_left;
                right_r  <= pcm_right;
                rds_r    <= pcm_rds;
                stereo_r <= stereo_en;
                rds_en_r <= rds_en;
                s19_r    <= sine_lut[SINE_ADDR_W'(phase >> (PHASE_W - SINE_ADDR_W))];
                s38_r    <= sine_lut[SINE_ADDR_W'((phase << 1) >> (PHASE_W - SINE_ADDR_W))];
                s57_r    <= sine_lut[SINE_ADDR_W'((phase + (phase << 1)) >> (PHASE_W - SINE_ADDR_W))];
            end
        end
    end

    assign sum_lr = {left_r[PCM_W-1], left_r} + {right_r[PCM_W-1], right_r};
    assign dif_lr = {left_r[PCM_W-1], left_r} - {right_r[PCM_W-1], right_r};

    // Product stage: full-width products, rescaled by the Q(PCM_W-1) sine and gated by mode
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mono_t  <= '0;
            diff_t  <= '0;
            pilot_t <= '0;
            rds_t   <= '0;
            valid_2 <= 1'b0;
        end else begin
            valid_2 <= valid_1;
            if (valid_1) begin
                mono_t  <= TERM_W'(stereo_r ? (sum_lr >>> 2) : (sum_lr >>> 1));
                diff_t  <= stereo_r
                           ? TERM_W'((PROD_W'(dif_lr >>> 2) * PROD_W'(s38_r)) >>> (PCM_W - 1))
                           : '0;
                pilot_t <= stereo_r
                           ? TERM_W'((PROD_W'(s19_r) * PROD_W'(PILOT_AMP)) >>> (PCM_W - 1))
                           : '0;
                rds_t   <= rds_en_r
                           ? TERM_W'(((PROD_W'(rds_r) * PROD_W'(s57_r)) >>> (PCM_W - 1)) >>> RDS_SHIFT)
                           : '0;
            end
        end
    end

    assign sum_c = SUM_W'(mono_t) + SUM_W'(diff_t) + SUM_W'(pilot_t) + SUM_W'(rds_t);

    // Clamp the wide sum to the PCM range so large mixes clip instead of wrapping
    always_comb begin
        sum_sat = sum_c[PCM_W-1:0];
        if (sum_c > MAX_V) begin
            sum_sat = MAX_V[PCM_W-1:0];
        end else if (sum_c < MIN_V) begin
            sum_sat = MIN_V[PCM_W-1:0];
        end
    end

    // Output stage: pcm_out only moves when a finished sample arrives
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pcm_out   <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= valid_2;
            if (valid_2) begin
                pcm_out <= sum_sat;
            end
        end
    end

endmodule

// File: tb/tb_fm_mpx_gen.sv
// tb_fm_mpx_gen: self-checking bench for fm_mpx_gen.
// Two instances share stimulus: one with a quarter-cycle phase step (exact
// 0/+FS/0/-FS carriers) and one with the real 19 kHz step and RDS shift.
module tb_fm_mpx_gen;

    localparam int          SAMPLE_DIV = 7;
    localparam int          PILOT_AMP  = 3277;
    localparam logic [31:0] INC_A      = 32'h4000_0000;
    localparam int          SHIFT_A    = 0;
    localparam logic [31:0] INC_B      = 32'd81604379;
    localparam int          SHIFT_B    = 2;

    logic               clk = 1'b0;
    logic               reset;
    logic               stereo_en;
    logic               rds_en;
    logic signed [15:0] pcm_left;
    logic signed [15:0] pcm_right;
    logic signed [15:0] pcm_rds;
    logic               tick_a;
    logic               tick_b;
    logic               valid_a;
    logic               valid_b;
    logic signed [15:0] out_a;
    logic signed [15:0] out_b;

    int checks     = 0;
    int errors     = 0;
    int sample_idx = 0;
    int exp_a_q[$];
    int exp_b_q[$];

    fm_mpx_gen #(
        .PCM_W(16), .SAMPLE_DIV(SAMPLE_DIV), .PHASE_W(32), .PILOT_INC(INC_A),
        .SINE_ADDR_W(8), .PILOT_AMP(PILOT_AMP), .RDS_SHIFT(SHIFT_A)
    ) dut_a (
        .clk(clk), .reset(reset), .stereo_en(stereo_en), .rds_en(rds_en),
        .pcm_left(pcm_left), .pcm_right(pcm_right), .pcm_rds(pcm_rds),
        .sample_tick(tick_a), .pcm_out(out_a), .out_valid(valid_a)
    );

    fm_mpx_gen #(
        .PCM_W(16), .SAMPLE_DIV(SAMPLE_DIV), .PHASE_W(32), .PILOT_INC(INC_B),
        .SINE_ADDR_W(8), .PILOT_AMP(PILOT_AMP), .RDS_SHIFT(SHIFT_B)
    ) dut_b (
        .clk(clk), .reset(reset), .stereo_en(stereo_en), .rds_en(rds_en),
        .pcm_left(pcm_left), .pcm_right(pcm_right), .pcm_rds(pcm_rds),
        .sample_tick(tick_b), .pcm_out(out_b), .out_valid(valid_b)
    );

    always #5 clk = ~clk;

    // Reference sine table entry straight from the real-valued formula
    function automatic int lut_model(input int idx);
        real v;
        v = 32767.0 * $sin(2.0 * 3.14159265358979323846 * real'(idx) / 256.0);
        if (v >= 0.0) return $rtoi(v + 0.5);
        return -$rtoi(0.5 - v);
    endfunction

    // Reference MPX sample for sample number n of a given phase step / RDS shift
    function automatic int mpx_model(input int l, input int r, input int rd,
                                     input bit st, input bit re,
                                     input logic [31:0] inc, input int rshift, input int n);
        logic [31:0] p;
        logic [31:0] p2;
        logic [31:0] p3;
        longint s19, s38, s57, mono, diff, pilot, rds, sum;
        p   = 32'(longint'(n) * longint'(inc));
        p2  = p << 1;
        p3  = p + p2;
        s19 = lut_model(int'(p[31:24]));
        s38 = lut_model(int'(p2[31:24]));
        s57 = lut_model(int'(p3[31:24]));
        mono  = st ? (longint'(l + r) >>> 2) : (longint'(l + r) >>> 1);
        diff  = st ? ((longint'((l - r) >>> 2) * s38) >>> 15) : 0;
        pilot = st ? ((s19 * PILOT_AMP) >>> 15) : 0;
        rds   = re ? (((longint'(rd) * s57) >>> 15) >>> rshift) : 0;
        sum   = mono + diff + pilot + rds;
        if (sum > 32767) sum = 32767;
        if (sum < -32768) sum = -32768;
        return int'(sum);
    endfunction

    task automatic check_output(input string tag, input logic signed [31:0] observed,
                                input logic signed [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_output("reset pcm_out a", out_a, 0);
        check_output("reset pcm_out b", out_b, 0);
        check_output("reset out_valid", valid_a, 0);
        check_output("reset sample_tick", tick_a, 0);
        @(negedge clk);
        reset = 1'b0;
        sample_idx = 0;
        exp_a_q.delete();
        exp_b_q.delete();
    endtask

    // Waits for the next tick, checking its spacing and that no stray out_valid shows up
    task automatic wait_tick(input string tag, input int gap);
        int cycles;
        bit saw_valid;
        cycles    = 0;
        saw_valid = 1'b0;
        do begin
            @(posedge clk);
            #1;
            cycles++;
            if (valid_a || valid_b) saw_valid = 1'b1;
        end while (!tick_a && cycles < 4 * SAMPLE_DIV);
        check_output({tag, " tick gap"}, cycles, gap);
        check_output({tag, " tick b"}, tick_b, 1);
        check_output({tag, " stray valid"}, saw_valid, 0);
    endtask

    task automatic apply_stimulus(input string tag, input int l, input int r, input int rd,
                                  input bit st, input bit re, input int gap);
        int exp_a;
        int exp_b;
        pcm_left  = 16'(l);
        pcm_right = 16'(r);
        pcm_rds   = 16'(rd);
        stereo_en = st;
        rds_en    = re;
        wait_tick(tag, gap);
        exp_a_q.push_back(mpx_model(l, r, rd, st, re, INC_A, SHIFT_A, sample_idx));
        exp_b_q.push_back(mpx_model(l, r, rd, st, re, INC_B, SHIFT_B, sample_idx));
        sample_idx++;
        @(posedge clk);
        #1;
        check_output({tag, " tick width"}, tick_a, 0);
        check_output({tag, " valid +1"}, valid_a, 0);
        pcm_left  = 16'($urandom);
        pcm_right = 16'($urandom);
        pcm_rds   = 16'($urandom);
        stereo_en = ~st;
        rds_en    = ~re;
        @(posedge clk);
        #1;
        check_output({tag, " valid +2"}, valid_a, 0);
        @(posedge clk);
        #1;
        check_output({tag, " valid a +3"}, valid_a, 1);
        check_output({tag, " valid b +3"}, valid_b, 1);
        exp_a = exp_a_q.pop_front();
        exp_b = exp_b_q.pop_front();
        check_output({tag, " pcm_out a"}, out_a, exp_a);
        check_output({tag, " pcm_out b"}, out_b, exp_b);
        @(posedge clk);
        #1;
        check_output({tag, " valid +4"}, valid_a, 0);
        check_output({tag, " hold a"}, out_a, exp_a);
    endtask

    initial begin
        reset     = 1'b0;
        stereo_en = 1'b0;
        rds_en    = 1'b0;
        pcm_left  = '0;
        pcm_right = '0;
        pcm_rds   = '0;
        apply_reset();

        apply_stimulus("first", 16'h4000, 16'h4000, 0, 1'b1, 1'b0, SAMPLE_DIV);

        for (int i = 0; i < 4; i++) begin
            apply_stimulus($sformatf("pilot%0d", i), 0, 0, 0, 1'b1, 1'b0, SAMPLE_DIV - 4);
        end

        for (int i = 0; i < 4; i++) begin
            apply_stimulus($sformatf("rds%0d", i), 0, 0, 32767, 1'b0, 1'b1, SAMPLE_DIV - 4);
        end

        apply_stimulus("mix1", 12000, -5000, -20000, 1'b1, 1'b1, SAMPLE_DIV - 4);
        apply_stimulus("mix2", -30000, 25000, 15000, 1'b1, 1'b1, SAMPLE_DIV - 4);
        apply_stimulus("sat pos", 32767, 32767, 32767, 1'b0, 1'b1, SAMPLE_DIV - 4);
        apply_stimulus("neg mono", -32768, -32768, 0, 1'b1, 1'b0, SAMPLE_DIV - 4);
        apply_stimulus("sat neg", -32768, -32768, 32767, 1'b0, 1'b1, SAMPLE_DIV - 4);

        wait_tick("mid rst", SAMPLE_DIV - 4);
        @(posedge clk);
        #1;
        apply_reset();

        apply_stimulus("restart", 16'h1000, 16'h1000, 0, 1'b1, 1'b0, SAMPLE_DIV);
        apply_stimulus("restart+1", 0, 0, 0, 1'b1, 1'b0, SAMPLE_DIV - 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
